// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Purpose : groups the ID/EX/WB-side signals that the hazard controller
//           observes and the stall/flush controls it produces.
// Modports:
//   master - pipeline side: drives the ID/EX/WB inputs and reads the controls.
//   slave  - hazard_ctrl side: reads the pipeline inputs and drives the controls.
// Signals :
//   id_valid, id_rs, id_rt, id_uses_rt, id_wr_en, id_wr_addr, id_mem_to_reg,
//   ex_redirect, wb_wr_en, wb_wr_addr                          (pipeline -> ctrl)
//   stall_if, stall_id, flush_id, flush_ex, busy_regs,
//   stall_timeout, state                                        (ctrl -> pipeline)
// Handshake: there is no valid/ready pairing here.  Every input is sampled on
//   every rising clk edge.  id_valid qualifies the ID fields, and wb_wr_en
//   qualifies wb_wr_addr.  Control outputs are valid in the same cycle they
//   are produced.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_uses_rt;
    logic              id_wr_en;
    logic [ADDR_W-1:0] id_wr_addr;
    logic              id_mem_to_reg;
    logic              ex_redirect;
    logic              wb_wr_en;
    logic [ADDR_W-1:0] wb_wr_addr;

    logic                stall_if;
    logic                stall_id;
    logic                flush_id;
    logic                flush_ex;
    logic [NUM_REGS-1:0] busy_regs;
    logic                stall_timeout;
    logic [1:0]          state;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_wr_en, id_wr_addr,
               id_mem_to_reg, ex_redirect, wb_wr_en, wb_wr_addr,
        input  stall_if, stall_id, flush_id, flush_ex, busy_regs,
               stall_timeout, state
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_wr_en, id_wr_addr,
               id_mem_to_reg, ex_redirect, wb_wr_en, wb_wr_addr,
        output stall_if, stall_id, flush_id, flush_ex, busy_regs,
               stall_timeout, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Purpose : pipeline hazard controller that sits beside the ID stage of a
//           5-stage MIPS core.  It keeps a per-register scoreboard of
//           in-flight writers and stalls IF/ID on RAW hazards.  While stalled
//           it injects a bubble into ID/EX.  When EX resolves a taken branch
//           or jump it squashes the wrong-path IF/ID instruction.
// Ports   :
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   hz    - hazard_ctrl_if.slave, which carries the ID/EX/WB inputs and the
//           stall_if/stall_id/flush_id/flush_ex/busy_regs/stall_timeout/state
//           outputs
// Config  : define HAZARD_FWD_EN when full EX/MEM/WB forwarding exists.  In
//           that build only a load-use pair stalls, for exactly one cycle.
//           Without it, any pending writer of a source register stalls ID.
// State   : 00 RUN, 01 STALL, 10 FLUSH.  The state is visible on hz.state.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 15
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q [NUM_REGS];
    logic [1:0]          cnt_d [NUM_REGS];
    logic [3:0]          flush_cnt_q, flush_cnt_d;
    logic [7:0]          stall_cnt_q, stall_cnt_d;
    logic                timeout_q, timeout_d;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] inc_vec, dec_vec;
    logic                hazard, issue, wb_dec;
    logic                stall_o, flush_id_o, flush_ex_o;

    // ---------------- scoreboard ----------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy[i] = (cnt_q[i] != 2'd0);
        end
    end

    // A squashed or stalled ID instruction never reaches EX, so it must not
    // be counted as a writer.
    assign issue   = hz.id_valid & ~stall_o & ~flush_id_o & hz.id_wr_en & (hz.id_wr_addr != '0);
    assign wb_dec  = hz.wb_wr_en & (hz.wb_wr_addr != '0);
    assign inc_vec = issue  ? (ONE_HOT0 << hz.id_wr_addr) : '0;
    assign dec_vec = wb_dec ? (ONE_HOT0 << hz.wb_wr_addr) : '0;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            case ({inc_vec[i], dec_vec[i]})
                2'b10:   if (cnt_q[i] != 2'd3) cnt_d[i] = cnt_q[i] + 2'd1;
                2'b01:   if (cnt_q[i] != 2'd0) cnt_d[i] = cnt_q[i] - 2'd1;
                default: cnt_d[i] = cnt_q[i];   // idle, or issue and WB cancel out
            endcase
        end
    end

    // ---------------- hazard detection ----------------
`ifdef HAZARD_FWD_EN
    // Forwarding covers every case except a load whose data arrives one
    // cycle too late for the instruction directly behind it.
    logic              ld_pending_q;
    logic [ADDR_W-1:0] ld_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_pending_q <= 1'b0;
            ld_addr_q    <= '0;
        end else begin
            ld_pending_q <= issue & hz.id_mem_to_reg;
            ld_addr_q    <= hz.id_wr_addr;
        end
    end

    assign hazard = hz.id_valid & ld_pending_q &
                    (((hz.id_rs != '0) & (hz.id_rs == ld_addr_q)) |
                     (hz.id_uses_rt & (hz.id_rt != '0) & (hz.id_rt == ld_addr_q)));
`else
    logic unused_mem_to_reg;
    assign unused_mem_to_reg = hz.id_mem_to_reg;

    assign hazard = hz.id_valid &
                    (((hz.id_rs != '0) & busy[hz.id_rs]) |
                     (hz.id_uses_rt & (hz.id_rt != '0) & busy[hz.id_rt]));
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= 2'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_FLUSH: begin
                if (hz.ex_redirect) begin
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                end else if (flush_cnt_q <= 4'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 4'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin   // RUN and STALL behave the same way
                if (hz.ex_redirect) begin
                    state_d     = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_RUN;
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                end else if (hazard) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase

        stall_cnt_d = stall_o ? ((stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1) : 8'd0;
        timeout_d   = timeout_q | (stall_cnt_d >= 8'(MAX_STALL));
    end

    // ---------------- FSM: outputs ----------------
    // Held at 0 while reset is asserted, even if ex_redirect is high.
    always_comb begin
        stall_o    = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
        if (reset) begin
            case (state_q)
                ST_FLUSH: begin
                    flush_id_o = 1'b1;
                    flush_ex_o = hz.ex_redirect;
                end
                default: begin
                    if (hz.ex_redirect) begin
                        flush_id_o = 1'b1;
                        flush_ex_o = 1'b1;
                    end else if (hazard) begin
                        stall_o    = 1'b1;
                        flush_ex_o = 1'b1;
                    end
                end
            endcase
        end
    end

    assign hz.stall_if      = stall_o;
    assign hz.stall_id      = stall_o;
    assign hz.flush_id      = flush_id_o;
    assign hz.flush_ex      = flush_ex_o;
    assign hz.busy_regs     = busy;
    assign hz.stall_timeout = timeout_q;
    assign hz.state         = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int NUM_REGS     = 32;
  localparam int ADDR_W       = 5;
  localparam int FLUSH_CYCLES = 1;
  localparam int MAX_STALL    = 15;
  localparam int VW           = 7 + NUM_REGS;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  hazard_ctrl_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) hz ();

  hazard_ctrl #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
    .FLUSH_CYCLES(FLUSH_CYCLES), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_cnt [NUM_REGS];
  bit m_flush;
  int m_flush_left;
  int m_run;
  bit m_tmo;
  bit m_stalled;
  bit m_ld_pend;
  int m_ld_addr;

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
    m_flush = 0; m_flush_left = 0; m_run = 0; m_tmo = 0;
    m_stalled = 0; m_ld_pend = 0; m_ld_addr = 0;
  endtask

  function automatic bit model_hazard();
`ifdef HAZARD_FWD_EN
    return hz.id_valid && m_ld_pend &&
           ((hz.id_rs != 0 && int'(hz.id_rs) == m_ld_addr) ||
            (hz.id_uses_rt && hz.id_rt != 0 && int'(hz.id_rt) == m_ld_addr));
`else
    return hz.id_valid &&
           ((hz.id_rs != 0 && m_cnt[hz.id_rs] > 0) ||
            (hz.id_uses_rt && hz.id_rt != 0 && m_cnt[hz.id_rt] > 0));
`endif
  endfunction

  // {stall, flush_id, flush_ex}
  function automatic logic [2:0] model_ctrl();
    if (m_flush) return {1'b0, 1'b1, hz.ex_redirect};
    if (hz.ex_redirect) return 3'b011;
    if (model_hazard()) return 3'b101;
    return 3'b000;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [2:0] c;
    logic [NUM_REGS-1:0] b;
    logic [1:0] st;
    c = model_ctrl();
    for (int i = 0; i < NUM_REGS; i++) b[i] = (m_cnt[i] != 0);
    st = m_flush ? 2'b10 : (m_stalled ? 2'b01 : 2'b00);
    return {c[2], c[2], c[1], c[0], m_tmo, st, b};
  endfunction

  function automatic logic [VW-1:0] actual_vec();
    return {hz.stall_if, hz.stall_id, hz.flush_id, hz.flush_ex,
            hz.stall_timeout, hz.state, hz.busy_regs};
  endfunction

  task automatic model_update();
    logic [2:0] c;
    bit issue, dec;
    int a, w;
    c = model_ctrl();
    a = int'(hz.id_wr_addr);
    w = int'(hz.wb_wr_addr);
    issue = hz.id_valid && !c[2] && !c[1] && hz.id_wr_en && a != 0;
    dec   = hz.wb_wr_en && w != 0;
    if (!(issue && dec && a == w)) begin
      if (issue && m_cnt[a] < 3) m_cnt[a]++;
      if (dec && m_cnt[w] > 0) m_cnt[w]--;
    end
    m_ld_pend = issue && hz.id_mem_to_reg;
    m_ld_addr = a;
    m_run = c[2] ? ((m_run < 255) ? m_run + 1 : 255) : 0;
    if (m_run >= MAX_STALL) m_tmo = 1;
    m_stalled = c[2];
    if (hz.ex_redirect) begin
      m_flush = (FLUSH_CYCLES > 0);
      m_flush_left = FLUSH_CYCLES;
    end else if (m_flush) begin
      m_flush_left--;
      if (m_flush_left == 0) m_flush = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    hz.id_valid = 0; hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 0;
    hz.id_wr_en = 0; hz.id_wr_addr = '0; hz.id_mem_to_reg = 0;
    hz.ex_redirect = 0; hz.wb_wr_en = 0; hz.wb_wr_addr = '0;
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit urt,
                        input bit we, input int wa, input bit ld);
    hz.id_valid = v; hz.id_rs = ADDR_W'(rs); hz.id_rt = ADDR_W'(rt);
    hz.id_uses_rt = urt; hz.id_wr_en = we; hz.id_wr_addr = ADDR_W'(wa);
    hz.id_mem_to_reg = ld;
  endtask

  task automatic set_wb(input bit en, input int addr);
    hz.wb_wr_en = en; hz.wb_wr_addr = ADDR_W'(addr);
  endtask

  // advance one clock: update model at the edge, return at the falling edge
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 0;
    @(negedge clk);
    hz.ex_redirect = 1;
    #1;
    n_tests++;
    if (actual_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected 0", actual_vec());
    end
    hz.ex_redirect = 0;
    @(negedge clk);
    reset = 1;
    model_reset();
    #1;
    n_tests++;
    if (actual_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", actual_vec(), model_vec());
    end
    @(negedge clk);
  endtask

  task automatic test_raw_stall();
    do_reset();
    set_id(1, 1, 2, 1, 1, 3, 0);          // add $3, $1, $2
    #1;
    n_tests++;
    if (hz.stall_id !== 1'b0 || actual_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL raw_issue: got %h expected %h", actual_vec(), model_vec());
    end
    tick();
    set_id(1, 3, 0, 0, 1, 4, 0);          // addi $4, $3, imm
    for (int k = 0; k < 4; k++) begin
      if (k == 3) set_wb(1, 3);
      #1;
      n_tests++;
      if (hz.stall_id !== 1'b1 || hz.flush_ex !== 1'b1 || hz.busy_regs[3] !== 1'b1 ||
          actual_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL raw_stall k=%0d: got %h expected %h", k, actual_vec(), model_vec());
      end
      tick();
    end
    set_wb(0, 0);
    #1;
    n_tests++;
    if (hz.stall_id !== 1'b0 || hz.busy_regs[3] !== 1'b0 || hz.state !== 2'b01 ||
        actual_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL raw_release: got %h expected %h", actual_vec(), model_vec());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_b [4];
    exp_b[0] = 2'b00; exp_b[1] = 2'b01; exp_b[2] = 2'b01; exp_b[3] = 2'b00;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      if (k < 2) set_id(1, 0, 0, 0, 1, 5, 0);
      if (k >= 2) set_wb(1, 5);
      #1;
      n_tests++;
      if (hz.busy_regs[5] !== ((k == 0) ? 1'b0 : 1'b1) || actual_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL b2b k=%0d: got %h expected %h", k, actual_vec(), model_vec());
      end
      tick();
    end
    idle_inputs();
    #1;
    n_tests++;
    if (hz.busy_regs[5] !== 1'b0 || actual_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL b2b_drain: got %h expected %h", actual_vec(), model_vec());
    end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(1, 0, 0, 0, 1, 6, 0);
    tick();
    set_id(1, 6, 0, 0, 0, 0, 0);
    hz.ex_redirect = 1;
    #1;
    n_tests++;
    if ({hz.flush_id, hz.flush_ex, hz.stall_id} !== 3'b110 || actual_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL redirect_now: got %h expected %h", actual_vec(), model_vec());
    end
    tick();
    hz.ex_redirect = 0;
    #1;
    n_tests++;
    if (hz.state !== 2'b10 || hz.flush_id !== 1'b1 || hz.stall_id !== 1'b0 ||
        actual_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL redirect_flush: got %h expected %h", actual_vec(), model_vec());
    end
    tick();
    #1;
    n_tests++;
    if (hz.state !== 2'b00 || hz.flush_id !== 1'b0 || actual_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL redirect_run: got %h expected %h", actual_vec(), model_vec());
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    set_id(1, 0, 0, 0, 1, 7, 0);
    tick();
    set_id(1, 7, 0, 0, 0, 0, 0);
    for (int j = 1; j <= MAX_STALL + 2; j++) begin
      tick();
      #1;
      n_tests++;
      if (hz.stall_timeout !== ((j >= MAX_STALL) ? 1'b1 : 1'b0) || actual_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL timeout j=%0d: got %h expected %h", j, actual_vec(), model_vec());
      end
    end
    set_wb(1, 7);
    tick();
    set_wb(0, 0);
    set_id(1, 1, 2, 1, 1, 0, 0);          // write to $0 is never tracked
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (hz.stall_timeout !== 1'b1 || hz.busy_regs !== '0 || actual_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL timeout_sticky_r0: got %h expected %h", actual_vec(), model_vec());
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1, 0, 0, 0, 1, 3, 0);
    tick();
    set_id(1, 3, 0, 0, 0, 0, 0);
    tick();
    tick();
    #1;
    reset = 0;
    #1;
    n_tests++;
    if (actual_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_stall: got %h expected 0", actual_vec());
    end
    @(negedge clk);
    idle_inputs();
    reset = 1;
    model_reset();
    @(negedge clk);
  endtask

`ifdef HAZARD_FWD_EN
  task automatic test_fwd();
    int stalls;
    do_reset();
    set_id(1, 1, 0, 0, 1, 2, 1);          // lw $2
    tick();
    set_id(1, 2, 3, 1, 1, 8, 0);          // add $8, $2, $3
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (hz.stall_id === 1'b1) stalls++;
      tick();
      if (hz.stall_id !== 1'b1) set_id(0, 0, 0, 0, 0, 0, 0);
    end
    n_tests++;
    if (stalls != 1) begin
      n_fail++;
      $display("FAIL fwd_load_use: got %0d stalls expected 1", stalls);
    end
    do_reset();
    set_id(1, 1, 1, 1, 1, 4, 0);          // add $4
    tick();
    set_id(1, 4, 4, 1, 1, 9, 0);          // sub $9, $4, $4
    #1;
    n_tests++;
    if (hz.stall_id !== 1'b0 || actual_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL fwd_alu_use: got %h expected %h", actual_vec(), model_vec());
    end
    tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_id($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0),
             $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(7, 0),
             $urandom_range(1, 0));
      hz.ex_redirect = ($urandom_range(15, 0) == 0);
      set_wb($urandom_range(1, 0), $urandom_range(7, 0));
      #1;
      n_tests++;
      if (actual_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random n=%0d: got %h expected %h", n, actual_vec(), model_vec());
      end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 0;
    idle_inputs();
    model_reset();
    test_reset();
`ifdef HAZARD_FWD_EN
    test_fwd();
`else
    test_raw_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid_stall();
`endif
    test_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
